syn_io_arbiter: RTL and testbench

SYN_IO_ARBITER -- requirements
Module: syn_io_arbiter

---
 rtl/syn_io_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_syn_io_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_io_arbiter.sv
// syn_io_arbiter: round-robin arbiter that lets several requesters share a
// single synapse IO unit. One operation is outstanding at a time: grant,
// start pulse, collect the channel-0/channel-1 result beats (or time out),
// then return a one-cycle response to the granted requester.

module syn_io_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 128,
    parameter int PAT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic [DATA_W-1:0]  resp_data0,
    output logic [DATA_W-1:0]  resp_data1,
    output logic [PAT_W-1:0]   resp_pat_ctr,
    output logic               resp_err,
    output logic               syn_start,
    input  logic               syn_busy,
    input  logic               syn_valid,
    input  logic               syn_channel,
    input  logic [DATA_W-1:0]  syn_data,
    input  logic [PAT_W-1:0]   syn_pat_ctr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CTR_W = 16;
    localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              got0, got1;
    logic [CTR_W-1:0]  wait_ctr;
    logic [DATA_W-1:0] data0, data1;
    logic [PAT_W-1:0]  pat;
    logic [DATA_W-1:0] data0_next, data1_next;
    logic [PAT_W-1:0]  pat_next;
    logic              capture0, capture1;
    logic              done, expired;

    assign capture0 = (state == WAIT) && syn_valid && !syn_channel;
    assign capture1 = (state == WAIT) && syn_valid && syn_channel;
    assign done     = got0 && got1 && !syn_busy;
    assign expired  = (wait_ctr == TIMEOUT_LAST);

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int cand;
        logic [IDX_W-1:0] cand_idx;
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Result values as they will look after this cycle's beat, so a beat
    // landing on the exit cycle still makes it into the response.
    always_comb begin
        data0_next = data0;
        data1_next = data1;
        pat_next   = pat;
        if (capture0) begin
            data0_next = syn_data;
        end
        if (capture1) begin
            data1_next = syn_data;
            pat_next   = syn_pat_ctr;
        end
    end

    // Next-state and handshake decode; req_ready is suppressed while reset is held.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        syn_start  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found && !syn_busy && !reset) begin
                    req_ready[pick_idx] = 1'b1;
                    state_next          = START;
                end
            end
            START: begin
                syn_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (done || expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid[grant_idx] = 1'b1;
                state_next            = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant bookkeeping: latch the winner, advance the pointer on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            if (state == IDLE && state_next == START) begin
                grant_idx <= pick_idx;
            end
            if (state == RESP) begin
                if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + IDX_W'(1);
                end
            end
        end
    end

    // Beat-arrival flags and WAIT cycle counter, cleared at the start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            got0     <= 1'b0;
            got1     <= 1'b0;
            wait_ctr <= '0;
        end else if (state == START) begin
            got0     <= 1'b0;
            got1     <= 1'b0;
            wait_ctr <= '0;
        end else if (state == WAIT) begin
            if (capture0) begin
                got0 <= 1'b1;
            end
            if (capture1) begin
                got1 <= 1'b1;
            end
            wait_ctr <= wait_ctr + CTR_W'(1);
        end
    end

    // Capture registers; only beats seen in WAIT are kept, last one wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data0 <= '0;
            data1 <= '0;
            pat   <= '0;
        end else begin
            data0 <= data0_next;
            data1 <= data1_next;
            pat   <= pat_next;
        end
    end

    // Response registers load on the way into RESP and then hold; the error
    // flag is cleared when a new operation starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_data0   <= '0;
            resp_data1   <= '0;
            resp_pat_ctr <= '0;
            resp_err     <= 1'b0;
        end else if (state == START) begin
            resp_err <= 1'b0;
        end else if (state == WAIT && state_next == RESP) begin
            resp_data0   <= data0_next;
            resp_data1   <= data1_next;
            resp_pat_ctr <= pat_next;
            resp_err     <= !done;
        end
    end

endmodule

// File: tb/tb_syn_io_arbiter.sv
// tb_syn_io_arbiter: drives requesters and a simple synapse IO model;
// expected responses are queued when each operation is launched and
// compared when the arbiter raises resp_valid.

module tb_syn_io_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 128;
    localparam int PAT_W   = 8;
    localparam int TIMEOUT = 20;

    logic               clk;
    logic               reset;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] resp_valid;
    logic [DATA_W-1:0]  resp_data0;
    logic [DATA_W-1:0]  resp_data1;
    logic [PAT_W-1:0]   resp_pat_ctr;
    logic               resp_err;
    logic               syn_start;
    logic               syn_busy;
    logic               syn_valid;
    logic               syn_channel;
    logic [DATA_W-1:0]  syn_data;
    logic [PAT_W-1:0]   syn_pat_ctr;

    syn_io_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data0  (resp_data0),
        .resp_data1  (resp_data1),
        .resp_pat_ctr(resp_pat_ctr),
        .resp_err    (resp_err),
        .syn_start   (syn_start),
        .syn_busy    (syn_busy),
        .syn_valid   (syn_valid),
        .syn_channel (syn_channel),
        .syn_data    (syn_data),
        .syn_pat_ctr (syn_pat_ctr)
    );

    typedef struct {
        logic [1:0]   hot;
        logic [127:0] d0;
        logic [127:0] d1;
        logic [7:0]   pat;
        logic         err;
    } exp_t;

    exp_t         sbq[$];
    exp_t         monE;
    int           errors     = 0;
    int           checks     = 0;
    int           startCount = 0;
    int           cyc        = 0;
    int           modelRr    = 0;
    logic [127:0] lastD0     = '0;
    logic [127:0] lastD1     = '0;
    logic [7:0]   lastPat    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every response is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (syn_start === 1'b1) startCount++;
        if (resp_valid !== '0) begin
            if (sbq.size() == 0) begin
                checkOutput("resp_unexpected", 128'(resp_valid), 128'(0));
            end else begin
                monE = sbq.pop_front();
                checkOutput("resp_onehot", 128'(resp_valid), 128'(monE.hot));
                checkOutput("resp_data0", resp_data0, monE.d0);
                checkOutput("resp_data1", resp_data1, monE.d1);
                checkOutput("resp_pat", 128'(resp_pat_ctr), 128'(monE.pat));
                checkOutput("resp_err", 128'(resp_err), 128'(monE.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int modelPick(input logic [1:0] mask);
        for (int i = 0; i < 2; i++) begin
            int c;
            c = (modelRr + i) % 2;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic waitGrant(input logic [1:0] mask, output int idx, output int waited);
        logic [1:0] hot;
        idx    = modelPick(mask);
        hot    = 2'b01 << idx;
        waited = 0;
        while (waited < 100) begin
            @(negedge clk);
            waited++;
            if (req_ready !== '0) break;
        end
        if (req_ready === '0) begin
            checkOutput("grant_timeout", 128'(1), 128'(0));
            idx = -1;
        end else begin
            checkOutput("grant_onehot", 128'(req_ready), 128'(hot));
        end
    endtask

    task automatic waitStart(output int ok);
        int n;
        n  = 0;
        ok = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (syn_start === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) checkOutput("start_timeout", 128'(1), 128'(0));
    endtask

    task automatic waitResp(output int ok);
        int n;
        n  = 0;
        ok = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (resp_valid !== '0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) checkOutput("resp_timeout", 128'(1), 128'(0));
    endtask

    // One complete operation: request, grant, optional beats, response.
    task automatic applyStimulus(input logic [1:0] mask, input bit hold,
                                 input logic [127:0] d0, input logic [127:0] d1,
                                 input logic [7:0] pat, input int delay,
                                 input int busyExtra, input bit sendBeats);
        int   idx, waited, ok, t0, startsBefore, expLat;
        exp_t e;
        req_valid = mask;
        idx       = modelPick(mask);
        e.hot     = 2'b01 << idx;
        e.d0      = sendBeats ? d0 : lastD0;
        e.d1      = sendBeats ? d1 : lastD1;
        e.pat     = sendBeats ? pat : lastPat;
        e.err     = !sendBeats;
        sbq.push_back(e);
        waitGrant(mask, idx, waited);
        if (idx < 0) return;
        checkOutput("grant_wait", 128'(waited), 128'(1));
        tick();
        startsBefore = startCount;
        req_valid    = hold ? mask : 2'b00;
        waitStart(ok);
        if (ok == 0) return;
        t0 = cyc;
        if (sendBeats) begin
            repeat (delay) @(posedge clk);
            #1;
            syn_valid   = 1'b1;
            syn_channel = 1'b0;
            syn_data    = d0;
            syn_busy    = (busyExtra > 0);
            tick();
            syn_channel = 1'b1;
            syn_data    = d1;
            syn_pat_ctr = pat;
            tick();
            syn_valid   = 1'b0;
            syn_channel = 1'b0;
            syn_data    = '0;
            syn_pat_ctr = '0;
            if (busyExtra > 0) begin
                repeat (busyExtra) tick();
                syn_busy = 1'b0;
            end
            lastD0  = d0;
            lastD1  = d1;
            lastPat = pat;
            expLat  = delay + 3 + busyExtra;
        end else begin
            expLat = TIMEOUT + 1;
        end
        waitResp(ok);
        if (ok == 0) return;
        checkOutput("latency", 128'(cyc - t0), 128'(expLat));
        modelRr = (idx + 1) % 2;
        tick();
        checkOutput("start_count", 128'(startCount - startsBefore), 128'(1));
    endtask

    task automatic strayBeats(input int n);
        for (int i = 0; i < n; i++) begin
            syn_valid   = 1'b1;
            syn_channel = i[0];
            syn_data    = {4{32'hdead_beef}} ^ 128'(i);
            syn_pat_ctr = 8'hee;
            tick();
        end
        syn_valid   = 1'b0;
        syn_channel = 1'b0;
        syn_data    = '0;
        syn_pat_ctr = '0;
    endtask

    task automatic checkAllZero(input string tagBase);
        checkOutput({tagBase, "_req_ready"}, 128'(req_ready), 128'(0));
        checkOutput({tagBase, "_resp_valid"}, 128'(resp_valid), 128'(0));
        checkOutput({tagBase, "_syn_start"}, 128'(syn_start), 128'(0));
        checkOutput({tagBase, "_resp_data0"}, resp_data0, 128'(0));
        checkOutput({tagBase, "_resp_data1"}, resp_data1, 128'(0));
        checkOutput({tagBase, "_resp_pat"}, 128'(resp_pat_ctr), 128'(0));
        checkOutput({tagBase, "_resp_err"}, 128'(resp_err), 128'(0));
    endtask

    initial begin
        int idx, waited, ok;
        reset       = 1'b1;
        req_valid   = 2'b01;
        syn_busy    = 1'b0;
        syn_valid   = 1'b0;
        syn_channel = 1'b0;
        syn_data    = '0;
        syn_pat_ctr = '0;

        #2;
        checkAllZero("reset");
        tick();
        tick();
        req_valid = 2'b00;
        reset     = 1'b0;
        tick();

        $display("[TB] single request");
        applyStimulus(2'b01, 1'b0, {4{32'haffe_affe}}, {4{32'habcd_0123}}, 8'h5a, 10, 0, 1'b1);

        $display("[TB] busy blocks grant");
        syn_busy  = 1'b1;
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("busy_no_grant", 128'(req_ready), 128'(0));
            checkOutput("busy_no_start", 128'(syn_start), 128'(0));
        end
        tick();
        syn_busy = 1'b0;
        applyStimulus(2'b10, 1'b0, {4{32'h0bad_cafe}}, {4{32'h7777_1234}}, 8'h33, 3, 0, 1'b1);

        $display("[TB] contention");
        applyStimulus(2'b11, 1'b1, {4{32'h1111_0000}}, {4{32'h1111_ffff}}, 8'h01, 2, 0, 1'b1);
        applyStimulus(2'b11, 1'b1, {4{32'h2222_0000}}, {4{32'h2222_ffff}}, 8'h02, 5, 3, 1'b1);
        applyStimulus(2'b11, 1'b1, {4{32'h3333_0000}}, {4{32'h3333_ffff}}, 8'h03, 1, 0, 1'b1);
        applyStimulus(2'b11, 1'b0, {4{32'h4444_0000}}, {4{32'h4444_ffff}}, 8'h04, 4, 0, 1'b1);

        $display("[TB] stray beats then timeout");
        strayBeats(4);
        applyStimulus(2'b01, 1'b0, '0, '0, '0, 1, 0, 1'b0);

        $display("[TB] stray beats then normal operation");
        strayBeats(3);
        applyStimulus(2'b01, 1'b0, {4{32'h5555_aaaa}}, {4{32'h6666_bbbb}}, 8'h66, 6, 0, 1'b1);

        $display("[TB] reset during WAIT");
        req_valid = 2'b10;
        waitGrant(2'b10, idx, waited);
        tick();
        req_valid = 2'b00;
        waitStart(ok);
        repeat (3) tick();
        req_valid = 2'b11;
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("midreset");
        req_valid = 2'b00;
        modelRr   = 0;
        lastD0    = '0;
        lastD1    = '0;
        lastPat   = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();

        $display("[TB] after reset");
        applyStimulus(2'b11, 1'b0, '0, '0, '0, 1, 0, 1'b0);
        applyStimulus(2'b11, 1'b0, {4{32'h9999_1357}}, {4{32'h8888_2468}}, 8'hc3, 2, 0, 1'b1);

        repeat (5) tick();
        checkOutput("sb_empty", 128'(sbq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
